// File: rtl/ecos_top_pkg.sv
// Shared constants and types for the ECOS pad and IP-selection fabric.
package ecos_top_pkg;

   localparam int N_IP_DEF          = 6;
   localparam int N_PAD_DEF         = 82;
   localparam int SWITCH_CYCLES_DEF = 16;
   localparam int SEL_W             = 3;

   typedef enum logic [1:0] {
      RESET  = 2'd0,
      SWITCH = 2'd1,
      RUN    = 2'd2
   } ecos_state_t;

   localparam int UART_RX  = 0;
   localparam int UART_TX  = 1;
   localparam int SPI_CLK  = 2;
   localparam int SPI_CS0  = 3;
   localparam int SPI_CS1  = 4;
   localparam int SPI_MOSI = 11;
   localparam int SPI_MISO = 12;

   // Idle-high lines (UART TX, SPI chip selects) are held inactive whenever no IP owns the pads.
   localparam logic [N_PAD_DEF-1:0] SAFE_OE  = (N_PAD_DEF'(1) << UART_TX)
                                             | (N_PAD_DEF'(1) << SPI_CS0)
                                             | (N_PAD_DEF'(1) << SPI_CS1);
   localparam logic [N_PAD_DEF-1:0] SAFE_VAL = SAFE_OE;

endpackage

// File: rtl/ecos_sync2.sv
// Two-flop synchroniser with asynchronous clear; used for both the reset and the select straps.
module ecos_sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ecos_asic_top.sv
// ECOS chip-level pad fabric: reset/select sync, reset-hold sequencing and the one-of-N pad mux.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   RESET  | synchronised reset active, every IP held, pads safe
//   SWITCH | reset-hold countdown, every IP held, pads safe
//   RUN    | active_sel owns the pads and is out of reset (if valid)
module ecos_asic_top
   import ecos_top_pkg::*;
#(
   parameter int N_IP          = N_IP_DEF,
   parameter int N_PAD         = N_PAD_DEF,
   parameter int SWITCH_CYCLES = SWITCH_CYCLES_DEF
) (
   input  logic             sys_clk_i_pad,
   input  logic             rst_n_pad,
   input  logic             ip_sel_pad0,
   input  logic             ip_sel_pad1,
   input  logic             ip_sel_pad2,
   output logic             sys_clk_o_pad,
   inout  wire  [N_PAD-1:0] io_pad,
   output logic             ip_clk,
   output logic [N_IP-1:0]  ip_rst_n,
   output logic [N_PAD-1:0] ip_io_in,
   input  logic [N_PAD-1:0] ip_io_out [N_IP],
   input  logic [N_PAD-1:0] ip_io_oe  [N_IP]
);

   localparam int                CNT_W    = (SWITCH_CYCLES > 2) ? $clog2(SWITCH_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SWITCH_CYCLES - 1);
   localparam logic [SEL_W:0]    N_IP_L   = (SEL_W + 1)'(N_IP);
   localparam logic [N_PAD-1:0]  SAFE_OE_L  = N_PAD'(SAFE_OE);
   localparam logic [N_PAD-1:0]  SAFE_VAL_L = N_PAD'(SAFE_VAL);

   logic             rst_sync_n;
   logic [SEL_W-1:0] sel_pad;
   logic [SEL_W-1:0] sel_sync;
   logic             sel_ok;

   ecos_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [SEL_W-1:0] active_sel, active_sel_nxt;
   logic             active_ok, active_ok_nxt;

   logic             run_ok;
   logic [N_PAD-1:0] drv_en;
   logic [N_PAD-1:0] drv_val;

   assign sys_clk_o_pad = sys_clk_i_pad;
   assign ip_clk        = sys_clk_i_pad;
   assign sel_pad       = {ip_sel_pad2, ip_sel_pad1, ip_sel_pad0};

   ecos_sync2 #(.WIDTH(1)) u_rst_sync (
      .clk   (sys_clk_i_pad),
      .rst_n (rst_n_pad),
      .d     (1'b1),
      .q     (rst_sync_n)
   );

   ecos_sync2 #(.WIDTH(SEL_W)) u_sel_sync (
      .clk   (sys_clk_i_pad),
      .rst_n (rst_sync_n),
      .d     (sel_pad),
      .q     (sel_sync)
   );

   always_ff @(posedge sys_clk_i_pad or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         state      <= RESET;
         cnt        <= '0;
         active_sel <= '0;
         active_ok  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         active_sel <= active_sel_nxt;
         active_ok  <= active_ok_nxt;
      end
   end

   always_comb begin
      // Written as an if so an unknown select resolves to "not valid" rather than propagating X.
      sel_ok = 1'b0;
      if ({1'b0, sel_sync} < N_IP_L) sel_ok = 1'b1;

      state_nxt      = state;
      cnt_nxt        = cnt;
      active_sel_nxt = active_sel;
      active_ok_nxt  = active_ok;

      case (state)
         RESET: begin
            state_nxt = SWITCH;
            cnt_nxt   = CNT_LOAD;
         end
         SWITCH: begin
            if (cnt == '0) begin
               state_nxt      = RUN;
               active_sel_nxt = sel_sync;
               active_ok_nxt  = sel_ok;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         RUN: begin
            if (sel_sync == active_sel) begin
               state_nxt = RUN;
            end else begin
               state_nxt = SWITCH;
               cnt_nxt   = CNT_LOAD;
            end
         end
         default: state_nxt = RESET;
      endcase
   end

   always_comb begin
      run_ok   = (state == RUN) && active_ok;
      ip_rst_n = '0;
      drv_en   = SAFE_OE_L;
      drv_val  = SAFE_VAL_L;
      if (run_ok) begin
         drv_en  = '0;
         drv_val = '0;
         for (int k = 0; k < N_IP; k++) begin
            if (active_sel == SEL_W'(k)) begin
               ip_rst_n[k] = 1'b1;
               drv_en      = ip_io_oe[k];
               drv_val     = ip_io_out[k];
            end
         end
      end
   end

   for (genvar i = 0; i < N_PAD; i++) begin : g_pad
      assign io_pad[i] = drv_en[i] ? drv_val[i] : 1'bz;
   end

   assign ip_io_in = io_pad;

endmodule

// File: tb/tb_ecos_asic_top.sv
// Directed bench for ecos_asic_top: reset release timing, selection changes, pad mux and safe state.
module tb_ecos_asic_top;

   localparam int NI = 6;
   localparam int NP = 82;

   localparam logic [NP-1:0] SAFE = 82'h1A;   // pads 1,3,4 driven high, rest pulled low
   localparam logic [NP-1:0] ALL1 = '1;

   logic          clk;
   logic          rst_n_pad;
   logic [2:0]    sel;
   logic          sys_clk_o_pad;
   logic          ip_clk;
   logic [NI-1:0] ip_rst_n;
   logic [NP-1:0] ip_io_in;
   logic [NP-1:0] ip_io_out [NI];
   logic [NP-1:0] ip_io_oe  [NI];
   logic          ext_en;
   wire  [NP-1:0] io_pad;

   int n_chk  = 0;
   int n_fail = 0;

   ecos_asic_top u_dut (
      .sys_clk_i_pad (clk),
      .rst_n_pad     (rst_n_pad),
      .ip_sel_pad0   (sel[0]),
      .ip_sel_pad1   (sel[1]),
      .ip_sel_pad2   (sel[2]),
      .sys_clk_o_pad (sys_clk_o_pad),
      .io_pad        (io_pad),
      .ip_clk        (ip_clk),
      .ip_rst_n      (ip_rst_n),
      .ip_io_in      (ip_io_in),
      .ip_io_out     (ip_io_out),
      .ip_io_oe      (ip_io_oe)
   );

   for (genvar i = 0; i < NP; i++) begin : g_pd
      pulldown (io_pad[i]);
   end

   assign io_pad[12] = ext_en ? 1'b1 : 1'bz;

   initial clk = 1'b0;
   always #20 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_ip(input int k, input logic [NP-1:0] oe, input logic [NP-1:0] dout);
      ip_io_oe[k]  = oe;
      ip_io_out[k] = dout;
   endtask

   initial begin
      rst_n_pad = 1'b0;
      sel       = 3'd0;
      ext_en    = 1'b0;
      for (int k = 0; k < NI; k++) set_ip(k, ALL1, ALL1);

      #1;
      chk("rst_ip_rst_n", 96'(ip_rst_n), 96'(6'b000000));
      chk("rst_pads",     96'(io_pad),   96'(SAFE));
      cyc(400);
      chk("rst_io_in",    96'(ip_io_in), 96'(SAFE));
      chk("clk_fwd",      96'({sys_clk_o_pad, ip_clk}), 96'(2'b11));

      // release with sel=0
      rst_n_pad = 1'b1;
      cyc(18);
      chk("rel0_c18_rst", 96'(ip_rst_n), 96'(6'b000000));
      chk("rel0_c18_pad", 96'(io_pad),   96'(SAFE));
      cyc(1);
      chk("rel0_c19_rst", 96'(ip_rst_n), 96'(6'b000001));
      chk("ip0_pads_all", 96'(io_pad),   96'(ALL1));
      set_ip(0, 82'h20, ALL1);
      #1;
      chk("ip0_pad5_only", 96'(io_pad),  96'(82'h20));

      // change 0 -> 1 in RUN
      sel = 3'd1;
      cyc(2);
      chk("sw01_c2_rst",  96'(ip_rst_n), 96'(6'b000001));
      cyc(1);
      chk("sw01_c3_rst",  96'(ip_rst_n), 96'(6'b000000));
      chk("sw01_c3_pad",  96'(io_pad),   96'(SAFE));
      ext_en = 1'b1;
      #1;
      chk("ext12_switch", 96'(ip_io_in[12]), 96'(1'b1));
      cyc(15);
      chk("sw01_c18_rst", 96'(ip_rst_n), 96'(6'b000000));
      cyc(1);
      chk("sw01_c19_rst", 96'(ip_rst_n), 96'(6'b000010));
      set_ip(1, 82'h2, ALL1);
      #1;
      chk("ext12_run",    96'(ip_io_in[12]), 96'(1'b1));
      ext_en = 1'b0;
      #1;
      chk("ip1_pad1_hi",  96'(io_pad),   96'(82'h2));
      set_ip(1, 82'h2, '0);
      #1;
      chk("ip1_pad1_lo",  96'(io_pad),   96'(82'h0));

      // async reset mid-RUN
      set_ip(1, ALL1, ALL1);
      #1;
      chk("ip1_pads_all", 96'(io_pad),   96'(ALL1));
      #5;
      rst_n_pad = 1'b0;
      #1;
      chk("async_rst",    96'(ip_rst_n), 96'(6'b000000));
      chk("async_pad",    96'(io_pad),   96'(SAFE));
      cyc(3);
      rst_n_pad = 1'b1;
      cyc(18);
      chk("rel1_c18_rst", 96'(ip_rst_n), 96'(6'b000000));
      cyc(1);
      chk("rel1_c19_rst", 96'(ip_rst_n), 96'(6'b000010));

      // invalid selection at release
      rst_n_pad = 1'b0;
      sel       = 3'd7;
      cyc(2);
      rst_n_pad = 1'b1;
      cyc(40);
      chk("inv7_rst",     96'(ip_rst_n), 96'(6'b000000));
      chk("inv7_pad",     96'(io_pad),   96'(SAFE));
      sel = 3'd2;
      cyc(18);
      chk("inv_sw2_c18",  96'(ip_rst_n), 96'(6'b000000));
      cyc(1);
      chk("inv_sw2_c19",  96'(ip_rst_n), 96'(6'b000100));

      // 2 -> 1, then back to 2 at counter 8: no restart
      sel = 3'd1;
      cyc(3);
      chk("tog_c3_rst",   96'(ip_rst_n), 96'(6'b000000));
      cyc(7);
      chk("tog_c10_rst",  96'(ip_rst_n), 96'(6'b000000));
      sel = 3'd2;
      cyc(8);
      chk("tog_c18_rst",  96'(ip_rst_n), 96'(6'b000000));
      cyc(1);
      chk("tog_c19_rst",  96'(ip_rst_n), 96'(6'b000100));
      cyc(5);
      chk("tog_hold_rst", 96'(ip_rst_n), 96'(6'b000100));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
